// File: rtl/reg_wr_arb_pkg.sv
// Shared types and constants for the register-bank write-port arbiter.
// Holds the arbiter FSM encoding, the x0 address and the index-width helper.
package reg_wr_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int X0_ADDR = 0;

    // Grant index width; a single requester still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_wr_arb_rr_pick.sv
// Rotating-priority encoder: first set bit of vld searching ptr, ptr+1, ... mod NREQ.
// Latency: purely combinational.
// Backpressure: none; gnt is one-hot or zero and simply follows vld/ptr.
module reg_wr_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] vld,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && vld[j]) begin
                gnt[j] = 1'b1;
                idx    = IW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arb.sv
// Round-robin arbiter sharing the register-bank write port among NREQ requesters, with burst lock.
// Latency: 1 cycle from handshake to wr_*; one write per cycle. REG_WR_ARB_X0_DROP_EN drops addr-0 writes.
// Backpressure: req_ready_o is a combinational one-hot grant; losers simply wait with valid held.
module reg_wr_arb
    import reg_wr_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    localparam int IW    = idx_width(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ-1:0]          req_lock_i,
    input  logic [NREQ*AWIDTH-1:0]   req_addr_i,
    input  logic [NREQ*DWIDTH-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic                     wr_we_o,
    output logic [AWIDTH-1:0]        wr_addr_o,
    output logic [DWIDTH-1:0]        wr_data_o,
    output logic [IW-1:0]            grant_id_o,
    output logic                     busy_o
);

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
        logic [IW-1:0]     id;
    } wr_t;

    arb_state_e      state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [IW-1:0]   sel_idx;
    logic            hs;
    logic            we_nxt;
    wr_t             sel_wr;
    wr_t             wr_q;
    logic            wr_we_q;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    reg_wr_arb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .vld (req_valid_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // A locked owner dropping valid releases the lock with no grant that cycle.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        case (state)
            ARB_IDLE: begin
                if (hs) begin
                    if (req_lock_i[sel_idx]) begin
                        state_nxt = ARB_LOCKED;
                        owner_nxt = sel_idx;
                    end else begin
                        rr_ptr_nxt = wrap_inc(sel_idx);
                    end
                end
            end
            ARB_LOCKED: begin
                if (!req_valid_i[owner] || !req_lock_i[owner]) begin
                    state_nxt  = ARB_IDLE;
                    rr_ptr_nxt = wrap_inc(owner);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        hs          = 1'b0;
        sel_idx     = pick_idx;
        if (rst) begin
            if (state == ARB_IDLE) begin
                req_ready_o = pick_gnt;
                hs          = pick_any;
            end else begin
                req_ready_o = req_valid_i & (NREQ'(1) << owner);
                hs          = req_valid_i[owner];
                sel_idx     = owner;
            end
        end
    end

    assign sel_wr.addr = req_addr_i[int'(sel_idx)*AWIDTH +: AWIDTH];
    assign sel_wr.data = req_data_i[int'(sel_idx)*DWIDTH +: DWIDTH];
    assign sel_wr.id   = sel_idx;

`ifdef REG_WR_ARB_X0_DROP_EN
    assign we_nxt = hs && (sel_wr.addr != AWIDTH'(X0_ADDR));
`else
    assign we_nxt = hs;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_we_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            wr_we_q <= we_nxt;
            if (hs) begin
                wr_q <= sel_wr;
            end
        end
    end

    assign wr_we_o    = wr_we_q;
    assign wr_addr_o  = wr_q.addr;
    assign wr_data_o  = wr_q.data;
    assign grant_id_o = wr_q.id;
    assign busy_o     = (state == ARB_LOCKED);

endmodule

// File: tb/tb_reg_wr_arb.sv
// Bench for reg_wr_arb: reference arbiter model + write scoreboard, plus directed scenario checks.
// Build with REG_WR_ARB_X0_DROP_EN defined to check the x0-drop variant.
module tb_reg_wr_arb;
    import reg_wr_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int IW   = 2;
`ifdef REG_WR_ARB_X0_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready_o;
    logic               wr_we_o;
    logic [AW-1:0]      wr_addr_o;
    logic [DW-1:0]      wr_data_o;
    logic [IW-1:0]      grant_id_o;
    logic               busy_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    bit   mon_en   = 1'b0;
    bit   exp_we   = 1'b0;
    bit   mstate   = 1'b0;
    int   mptr     = 0;
    int   mowner   = 0;

    reg_wr_arb #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_lock_i  (req_lock),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready_o),
        .wr_we_o     (wr_we_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit lk, input int a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_lock[i]           = lk;
        req_addr[i*AW +: AW]  = AW'(a);
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic reset_model();
        mstate = 1'b0;
        mptr   = 0;
        mowner = 0;
        exp_we = 1'b0;
        sb.delete();
    endtask

    // Returns at the falling edge where requester i is granted.
    task automatic wait_hs(input int i);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req_valid[i] && req_ready_o[i];
        end
        check("hs_seen", got, 1);
    endtask

    // Retire every outstanding request as it is granted.
    task automatic drain();
        logic [NREQ-1:0] hsv;
        for (int n = 0; n < 16 && req_valid != 0; n++) begin
            @(negedge clk);
            hsv = req_valid & req_ready_o;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~hsv;
        end
        check("drain", req_valid, 0);
    endtask

    // Reference model: predicts ready each cycle, queues the expected write.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [NREQ-1:0] er;
            int   w;
            int   j;
            exp_t e;
            check("we", wr_we_o, exp_we);
            if (wr_we_o) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", wr_addr_o, e.a);
                    check("wr_data", wr_data_o, e.d);
                    check("grant_id", grant_id_o, e.id);
                end
            end
            check("busy", busy_o, mstate);
            er = '0;
            w  = -1;
            if (!mstate) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (mptr + k) % NREQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
            end else if (req_valid[mowner]) begin
                w = mowner;
            end
            if (w >= 0) er[w] = 1'b1;
            check("ready", req_ready_o, er);
            exp_we = 1'b0;
            if (w >= 0) begin
                e.a  = req_addr[w*AW +: AW];
                e.d  = req_data[w*DW +: DW];
                e.id = IW'(w);
                if (!(DROP && e.a == AW'(X0_ADDR))) begin
                    sb.push_back(e);
                    exp_we = 1'b1;
                end
            end
            if (!mstate) begin
                if (w >= 0) begin
                    if (req_lock[w]) begin
                        mstate = 1'b1;
                        mowner = w;
                    end else begin
                        mptr = (w + 1) % NREQ;
                    end
                end
            end else if (!req_valid[mowner] || !req_lock[mowner]) begin
                mstate = 1'b0;
                mptr   = (mowner + 1) % NREQ;
            end
        end
    end

    initial begin
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i + 1, 32'hA000_0000 + 32'(i));

        // 1: ready and we held low through reset, req0 first after release
        repeat (3) begin
            @(negedge clk);
            check("t1_rdy_rst", req_ready_o, 0);
            check("t1_we_rst", wr_we_o, 0);
            check("t1_busy_rst", busy_o, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_model();
        mon_en = 1'b1;
        @(negedge clk);
        check("t1_first", req_ready_o, 4'b0001);

        // 2: continuous round robin
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_we", wr_we_o, 1);
            check("t2_addr", wr_addr_o, (k % 4) + 1);
            check("t2_id", grant_id_o, k % 4);
        end
        drain();

        // 3: locked burst A,B,C from req2, then req3 is next
        repeat (2) @(posedge clk);
        #1;
        set_req(2, 1'b1, 1'b1, 10, 32'hAAAA_0001);
        wait_hs(2);
        @(posedge clk);
        #1;
        check("t3_dataA", wr_data_o, 32'hAAAA_0001);
        check("t3_idA", grant_id_o, 2);
        check("t3_busyA", busy_o, 1);
        set_req(2, 1'b1, 1'b1, 10, 32'hBBBB_0002);
        set_req(0, 1'b1, 1'b0, 1, 32'h0000_0100);
        set_req(1, 1'b1, 1'b0, 2, 32'h0000_0101);
        set_req(3, 1'b1, 1'b0, 4, 32'h0000_0103);
        wait_hs(2);
        @(posedge clk);
        #1;
        check("t3_dataB", wr_data_o, 32'hBBBB_0002);
        check("t3_busyB", busy_o, 1);
        set_req(2, 1'b1, 1'b0, 10, 32'hCCCC_0003);
        wait_hs(2);
        @(posedge clk);
        #1;
        check("t3_dataC", wr_data_o, 32'hCCCC_0003);
        check("t3_idC", grant_id_o, 2);
        check("t3_busyC", busy_o, 0);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("t3_next", req_ready_o, 4'b1000);
        drain();

        // 4: lone requester, single write
        repeat (2) @(posedge clk);
        #1;
        set_req(1, 1'b1, 1'b0, 7, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t4_rdy", req_ready_o, 4'b0010);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("t4_we", wr_we_o, 1);
        check("t4_addr", wr_addr_o, 7);
        check("t4_data", wr_data_o, 32'hDEAD_BEEF);
        check("t4_id", grant_id_o, 1);
        @(posedge clk);
        #1;
        check("t4_we_off", wr_we_o, 0);
        check("t4_hold", wr_addr_o, 7);

        // 5: async reset mid-cycle while locked
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b1, 3, 32'h0000_0055);
        wait_hs(0);
        @(posedge clk);
        #1;
        check("t5_busy", busy_o, 1);
        check("t5_we", wr_we_o, 1);
        set_req(0, 1'b1, 1'b1, 3, 32'h0000_0056);
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_we_rst", wr_we_o, 0);
        check("t5_busy_rst", busy_o, 0);
        check("t5_rdy_rst", req_ready_o, 0);
        check("t5_addr_rst", wr_addr_o, 0);
        check("t5_data_rst", wr_data_o, 0);
        check("t5_id_rst", grant_id_o, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i + 1, 32'hB000_0000 + 32'(i));
        rst = 1'b1;
        reset_model();
        mon_en = 1'b1;
        @(negedge clk);
        check("t5_ptr0", req_ready_o, 4'b0001);
        drain();

        // 6: write to address 0
        repeat (2) @(posedge clk);
        #1;
        set_req(3, 1'b1, 1'b0, X0_ADDR, 32'h0000_1234);
        @(negedge clk);
        check("t6_rdy", req_ready_o, 4'b1000);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        check("t6_we", wr_we_o, DROP ? 0 : 1);
        check("t6_addr", wr_addr_o, X0_ADDR);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
